// File: rtl/condlogic_pkg.sv
// Shared controller definitions: ARM condition-code encodings and NZCV bit positions.
package condlogic_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/condcheck.sv
// Combinational condition evaluator: maps the 4-bit condition field and the
// registered NZCV flags to a single execute/skip decision.
module condcheck
    import condlogic_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            // Unpredictable encoding is pinned to "never execute".
            COND_NV: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/condlogic.sv
// Conditional-execution unit: owns the NZCV flag register and gates decode
// intents into the PC, register-file and memory write strobes.
module condlogic
    import condlogic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags
);

    logic [1:0] nz_reg;
    logic [1:0] cv_reg;
    logic       condex_delayed_reg;
    logic       condex;
    logic [1:0] flag_write;

    assign Flags = {nz_reg, cv_reg};

    condcheck u_condcheck (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (condex)
    );

    assign flag_write = FlagW & {2{condex}};

    // Each flag half updates independently; CondEx is delayed so writeback
    // strobes see the decision made before this instruction's own flag update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_reg             <= 2'b00;
            cv_reg             <= 2'b00;
            condex_delayed_reg <= 1'b0;
        end else begin
            if (flag_write[1]) begin
                nz_reg <= ALUFlags[FLAG_N:FLAG_Z];
            end
            if (flag_write[0]) begin
                cv_reg <= ALUFlags[FLAG_C:FLAG_V];
            end
            condex_delayed_reg <= condex;
        end
    end

    // Fetch advances the PC regardless of the condition outcome.
    assign PCWrite  = (PCS & condex_delayed_reg) | NextPC;
    assign RegWrite = RegW & condex_delayed_reg;
    assign MemWrite = MemW & condex_delayed_reg;

endmodule
